// File: rtl/inst_addr_ctrl_if.sv
// Fetch handshake, decode flags and PC-mux controls exchanged with the instruction address controller.
interface inst_addr_ctrl_if #(
    parameter int unsigned DEPTH_W = 3
);
    logic               InstAck;
    logic               Stall;
    logic               IsBranch;
    logic               BranchTaken;
    logic               IsCall;
    logic               IsReturn;
    logic               InstReq;
    logic               PC_select;
    logic               INC_select;
    logic               PC_enable;
    logic [DEPTH_W-1:0] Depth;
    logic               Fault;

    modport master (
        input  InstAck, Stall, IsBranch, BranchTaken, IsCall, IsReturn,
        output InstReq, PC_select, INC_select, PC_enable, Depth, Fault
    );

    modport slave (
        output InstAck, Stall, IsBranch, BranchTaken, IsCall, IsReturn,
        input  InstReq, PC_select, INC_select, PC_enable, Depth, Fault
    );
endinterface

// File: rtl/inst_addr_ctrl.sv
// Instruction address controller: fetch/decode/update sequencing, call-depth tracking and
// sticky fault on fetch timeout or call-stack over/underflow.
module inst_addr_ctrl #(
    parameter int unsigned DEPTH_W = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input logic              Clock,
    input logic              Reset,
    inst_addr_ctrl_if.master bus_io
);
    localparam int unsigned TimerW = $clog2(TIMEOUT + 1);
    localparam logic [DEPTH_W-1:0] DepthMax = '1;

    typedef enum logic [2:0] {StIdle, StFetch, StDecode, StUpdate, StFault} state_e;

    state_e              state_q, state_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic                ret_q, ret_d;
    logic                br_q, br_d;
    logic                call_q, call_d;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StIdle;
            timer_q <= '0;
            depth_q <= '0;
            ret_q   <= 1'b0;
            br_q    <= 1'b0;
            call_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            depth_q <= depth_d;
            ret_q   <= ret_d;
            br_q    <= br_d;
            call_q  <= call_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        depth_d = depth_q;
        ret_d   = ret_q;
        br_d    = br_q;
        call_d  = call_q;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (bus_io.InstAck) begin
                    timer_d = '0;
                    state_d = StDecode;
                end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
                    state_d = StFault;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StDecode: begin
                if (!bus_io.Stall) begin
                    // Return with an empty call stack never reaches UPDATE.
                    if (bus_io.IsReturn && depth_q == '0) begin
                        state_d = StFault;
                    end else begin
                        ret_d   = bus_io.IsReturn;
                        br_d    = !bus_io.IsReturn && bus_io.IsBranch && bus_io.BranchTaken;
                        call_d  = br_d && bus_io.IsCall;
                        state_d = StUpdate;
                    end
                end
            end
            StUpdate: begin
                state_d = StFetch;
                if (ret_q) begin
                    depth_d = depth_q - 1'b1;
                end else if (call_q) begin
                    // Overflowing call still loads the PC this cycle, then faults.
                    if (depth_q == DepthMax) begin
                        state_d = StFault;
                    end else begin
                        depth_d = depth_q + 1'b1;
                    end
                end
            end
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase
    end

    assign bus_io.InstReq    = (state_q == StFetch);
    assign bus_io.PC_enable  = (state_q == StUpdate);
    assign bus_io.PC_select  = !((state_q == StUpdate) && ret_q);
    assign bus_io.INC_select = (state_q == StUpdate) && br_q;
    assign bus_io.Depth      = depth_q;
    assign bus_io.Fault      = (state_q == StFault);
endmodule

// File: tb/tb_inst_addr_ctrl.sv
// Directed-vector bench for inst_addr_ctrl: sequencing, depth tracking, stall, timeout and faults.
module tb_inst_addr_ctrl;
    logic Clock;
    logic Reset;
    int   n_checks;
    int   n_fail;

    inst_addr_ctrl_if #(.DEPTH_W(3)) bus ();

    inst_addr_ctrl #(
        .DEPTH_W(3),
        .TIMEOUT(15)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus_io(bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic set_dec(input logic br, input logic tk, input logic call, input logic ret);
        bus.IsBranch    = br;
        bus.BranchTaken = tk;
        bus.IsCall      = call;
        bus.IsReturn    = ret;
    endtask

    // Leaves the bench at the negedge of the first post-reset cycle (state IDLE).
    task automatic do_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
    endtask

    // Advance until a PC_enable pulse is seen (bounded); returns the mux selects.
    task automatic wait_update(input string tag, output int pcs, output int incs);
        bit found;
        found = 1'b0;
        pcs   = -1;
        incs  = -1;
        for (int i = 0; i < 20; i++) begin
            if (bus.PC_enable) begin
                found = 1'b1;
                pcs   = int'(bus.PC_select);
                incs  = int'(bus.INC_select);
                break;
            end
            step();
        end
        if (!found) check({tag, "_no_update"}, 0, 1);
    endtask

    initial begin
        int pcs, incs, reqs;
        n_checks = 0;
        n_fail   = 0;
        Reset    = 1'b1;
        bus.InstAck = 1'b0;
        bus.Stall   = 1'b0;
        set_dec(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge Clock);

        // Outputs while held in reset.
        step();
        check("rst_instreq", int'(bus.InstReq), 0);
        check("rst_pcen", int'(bus.PC_enable), 0);
        check("rst_pcsel", int'(bus.PC_select), 1);
        check("rst_incsel", int'(bus.INC_select), 0);
        check("rst_depth", int'(bus.Depth), 0);
        check("rst_fault", int'(bus.Fault), 0);

        // Sequential stream: pulses on cycles 4, 7, 10 after release.
        bus.InstAck = 1'b1;
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            check($sformatf("seq_pcen_c%0d", c), int'(bus.PC_enable),
                  (c == 4 || c == 7 || c == 10) ? 1 : 0);
            check($sformatf("seq_instreq_c%0d", c), int'(bus.InstReq),
                  (c == 2 || c == 5 || c == 8) ? 1 : 0);
            if (c == 4 || c == 7 || c == 10) begin
                check($sformatf("seq_pcsel_c%0d", c), int'(bus.PC_select), 1);
                check($sformatf("seq_incsel_c%0d", c), int'(bus.INC_select), 0);
            end
            step();
        end

        // Three calls then three returns.
        do_reset();
        set_dec(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            wait_update("call", pcs, incs);
            check($sformatf("call%0d_pcsel", i), pcs, 1);
            check($sformatf("call%0d_incsel", i), incs, 1);
            step();
            check($sformatf("call%0d_depth", i), int'(bus.Depth), i);
        end
        set_dec(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            wait_update("ret", pcs, incs);
            check($sformatf("ret%0d_pcsel", i), pcs, 0);
            check($sformatf("ret%0d_incsel", i), incs, 0);
            step();
            check($sformatf("ret%0d_depth", i), int'(bus.Depth), 3 - i);
            check($sformatf("ret%0d_fault", i), int'(bus.Fault), 0);
        end

        // Fourth return at Depth=0: FETCH, DECODE, then FAULT with no PC load.
        for (int k = 0; k < 8; k++) begin
            check($sformatf("uflow_pcen_k%0d", k), int'(bus.PC_enable), 0);
            check($sformatf("uflow_fault_k%0d", k), int'(bus.Fault), (k >= 2) ? 1 : 0);
            check($sformatf("uflow_depth_k%0d", k), int'(bus.Depth), 0);
            step();
        end
        check("uflow_instreq", int'(bus.InstReq), 0);
        Reset = 1'b1;
        step();
        check("uflow_rst_fault", int'(bus.Fault), 0);
        Reset = 1'b0;

        // Fetch timeout: InstReq high for exactly 15 cycles.
        set_dec(1'b0, 1'b0, 1'b0, 1'b0);
        bus.InstAck = 1'b0;
        do_reset();
        reqs = 0;
        for (int c = 0; c < 25; c++) begin
            if (bus.InstReq) reqs++;
            step();
        end
        check("tmo_req_cycles", reqs, 15);
        check("tmo_fault", int'(bus.Fault), 1);
        check("tmo_instreq", int'(bus.InstReq), 0);

        // Reset mid-FETCH takes priority.
        do_reset();
        step();
        step();
        check("midfetch_instreq", int'(bus.InstReq), 1);
        Reset = 1'b1;
        step();
        check("midfetch_rst_instreq", int'(bus.InstReq), 0);
        Reset = 1'b0;

        // Stall held five cycles in DECODE with a taken branch.
        bus.InstAck = 1'b1;
        bus.Stall   = 1'b1;
        set_dec(1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall_pcen_k%0d", k), int'(bus.PC_enable), 0);
            check($sformatf("stall_instreq_k%0d", k), int'(bus.InstReq), 0);
            step();
        end
        bus.Stall = 1'b0;
        check("stall_release_pcen", int'(bus.PC_enable), 0);
        step();
        check("stall_upd_pcen", int'(bus.PC_enable), 1);
        check("stall_upd_incsel", int'(bus.INC_select), 1);
        check("stall_upd_pcsel", int'(bus.PC_select), 1);
        step();
        check("stall_single_pulse", int'(bus.PC_enable), 0);

        // Eight nested calls overflow a 3-bit depth counter.
        set_dec(1'b1, 1'b1, 1'b1, 1'b0);
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            wait_update("nest", pcs, incs);
            check($sformatf("nest%0d_incsel", i), incs, 1);
            step();
            check($sformatf("nest%0d_depth", i), int'(bus.Depth), (i == 8) ? 7 : i);
            check($sformatf("nest%0d_fault", i), int'(bus.Fault), (i == 8) ? 1 : 0);
        end
        step();
        check("nest_fault_sticky", int'(bus.Fault), 1);
        check("nest_fault_pcen", int'(bus.PC_enable), 0);
        Reset = 1'b1;
        step();
        check("nest_rst_depth", int'(bus.Depth), 0);
        check("nest_rst_fault", int'(bus.Fault), 0);
        step();
        Reset = 1'b0;
        check("nest_idle_instreq", int'(bus.InstReq), 0);
        step();
        check("nest_fetch_instreq", int'(bus.InstReq), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
